bo_datapath: RTL and testbench

Operative block (datapath) driven by the BC control FSM. It receives BC's registered load enables (LX, LS, LH), ALU operation select (H) and the three 2-bit mux selects (M0, M1, M2). It owns three working registers and a shared ALU, and returns the result and status flags. Over BC's A→F sequence it computes y = x³ + x modulo 2^WIDTH from a sampled operand.

---
 rtl/bo_datapath.sv | 54 +++++
 tb/tb_bo_datapath.sv | 110 +++++++++++
 2 files changed

// File: rtl/bo_datapath.sv
// bo_datapath: three-register datapath with shared add/multiply ALU computing y = x^3 + x under BC control
module bo_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic             LX,
  input  logic             LH,
  input  logic             LS,
  input  logic             H,
  input  logic [1:0]       M0,
  input  logic [1:0]       M1,
  input  logic [1:0]       M2,
  output logic [WIDTH-1:0] y,
  output logic             y_zero,
  output logic             ovf
);
  logic [WIDTH-1:0]   x_q, x_d, t_q, t_d, s_q, s_d;
  logic [WIDTH-1:0]   a, b, alu_r, s_wr;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic               alu_ovf, ovf_q, ovf_d;
  always_comb begin
    a       = M0 == 2'd0 ? x_in : M0 == 2'd1 ? x_q : M0 == 2'd2 ? t_q : s_q;
    b       = M1 == 2'd0 ? x_q : M1 == 2'd1 ? x_in : M1 == 2'd2 ? s_q : '0;
    prod    = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    sum     = {1'b0, a} + {1'b0, b};
    alu_r   = H ? prod[WIDTH-1:0] : sum[WIDTH-1:0];
    alu_ovf = H ? |prod[2*WIDTH-1:WIDTH] : sum[WIDTH];
    s_wr    = M2 == 2'd0 ? '0 : M2 == 2'd1 ? x_in : M2 == 2'd2 ? alu_r : t_q;
    x_d     = LX ? x_in : x_q;
    t_d     = LH ? alu_r : t_q;
    s_d     = LS ? s_wr : s_q;
    // LX starts a new computation, so its clear beats a coincident overflow
    ovf_d   = LX ? 1'b0 : ((LH || (LS && M2 == 2'd2)) && alu_ovf) ? 1'b1 : ovf_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q   <= '0;
      t_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      t_q   <= t_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end
  assign y      = s_q;
  assign y_zero = s_q == '0;
  assign ovf    = ovf_q;
endmodule

// File: tb/tb_bo_datapath.sv
// tb_bo_datapath: directed vectors; stimulus queues expected y/ovf, a monitor pops and compares
module tb_bo_datapath;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] x_in = '0;
  logic       LX = 1'b0, LH = 1'b0, LS = 1'b0, H = 1'b0;
  logic [1:0] M0 = '0, M1 = '0, M2 = '0;
  logic [7:0] y;
  logic       y_zero, ovf;

  bo_datapath #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .x_in(x_in), .LX(LX), .LH(LH), .LS(LS), .H(H),
    .M0(M0), .M1(M1), .M2(M2), .y(y), .y_zero(y_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [7:0] y;
    logic       ov;
  } exp_t;

  exp_t q[$];
  exp_t e;
  event chk_ev;
  int   applied = 0;
  int   miscompares = 0;

  always begin
    @(negedge clk or chk_ev);
    while (q.size() > 0) begin
      e = q.pop_front();
      applied++;
      if (y !== e.y || y_zero !== (e.y == 8'd0) || ovf !== e.ov) begin
        miscompares++;
        $display("FAIL %s: got y=%0d y_zero=%b ovf=%b, want y=%0d y_zero=%b ovf=%b",
                 e.nm, y, y_zero, ovf, e.y, (e.y == 8'd0), e.ov);
      end
    end
  end

  task automatic step(input string nm, input logic lx, lh, ls, h,
                      input logic [1:0] m0, m1, m2, input logic [7:0] x,
                      input logic [7:0] ey, input logic eo);
    @(negedge clk);
    LX = lx; LH = lh; LS = ls; H = h; M0 = m0; M1 = m1; M2 = m2; x_in = x;
    @(posedge clk);
    #1;
    q.push_back('{nm, ey, eo});
    LX = 1'b0; LH = 1'b0; LS = 1'b0;
  endtask

  task automatic async_reset_check(input string nm);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 q.push_back('{nm, 8'd0, 1'b0});
    ->chk_ev;
    #1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #2 q.push_back('{"reset_init", 8'd0, 1'b0});
    ->chk_ev;
    @(negedge clk);
    reset = 1'b1;
    // x = 3: 27 + 3 = 30
    step("x3_A", 1, 1, 0, 1, 2'd0, 2'd1, 2'd0, 8'd3, 8'd0, 0);
    step("x3_B", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd9, 0);
    step("x3_C", 0, 1, 0, 1, 2'd2, 2'd0, 2'd0, 8'd0, 8'd9, 0);
    step("x3_D", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd27, 0);
    step("x3_E", 0, 0, 1, 0, 2'd3, 2'd0, 2'd2, 8'd0, 8'd30, 0);
    step("x3_F1", 0, 0, 0, 1, 2'd1, 2'd2, 2'd1, 8'd77, 8'd30, 0);
    step("x3_F2", 0, 0, 0, 0, 2'd2, 2'd3, 2'd0, 8'd11, 8'd30, 0);
    // x = 7: 343 wraps to 87 with overflow, then 87 + 7 = 94
    step("x7_A", 1, 1, 0, 1, 2'd0, 2'd1, 2'd0, 8'd7, 8'd30, 0);
    step("x7_B", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd49, 0);
    step("x7_C", 0, 1, 0, 1, 2'd2, 2'd0, 2'd0, 8'd0, 8'd49, 1);
    step("x7_D", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd87, 1);
    step("x7_E", 0, 0, 1, 0, 2'd3, 2'd0, 2'd2, 8'd0, 8'd94, 1);
    step("lx_clears_ovf", 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd100, 8'd94, 0);
    // 200 + 100 carries out
    step("load_s200", 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 8'd200, 8'd200, 0);
    step("add_ovf", 0, 0, 1, 0, 2'd3, 2'd0, 2'd2, 8'd0, 8'd44, 1);
    // simultaneous LH/LS: S takes the pre-edge T
    step("load_x2", 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 8'd2, 8'd44, 0);
    step("load_t5", 0, 1, 0, 0, 2'd0, 2'd3, 2'd0, 8'd5, 8'd44, 0);
    step("simul_s_old_t", 0, 1, 1, 1, 2'd2, 2'd0, 2'd3, 8'd0, 8'd5, 0);
    step("simul_t_new", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd10, 0);
    for (int i = 0; i < 20; i++)
      step("idle_hold", 0, 0, 0, 1'($urandom_range(1)), 2'($urandom_range(3)),
           2'($urandom_range(3)), 2'($urandom_range(3)), 8'($urandom_range(255)), 8'd10, 0);
    step("s_zero", 0, 0, 1, 0, 2'd0, 2'd0, 2'd0, 8'd9, 8'd0, 0);
    step("s_x_in", 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 8'd13, 8'd13, 0);
    // 200 * 200 = 40000 -> T = 64, ovf set
    step("mul_ovf_lh", 0, 1, 0, 1, 2'd0, 2'd1, 2'd0, 8'd200, 8'd13, 1);
    async_reset_check("reset_mid");
    step("t_cleared", 0, 0, 1, 0, 2'd0, 2'd0, 2'd3, 8'd0, 8'd0, 0);
    step("post_reset_load", 0, 0, 1, 0, 2'd0, 2'd0, 2'd1, 8'd42, 8'd42, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
